// File: rtl/spi_flash_block_streamer.sv
// spi_flash_block_streamer
//   Front end for spi_flash_ctrl. Requests one flash block at a time, captures
//   the controller's BRAM-write byte stream into a ping-pong buffer
//   (2 x BLOCK_SIZE bytes) and replays it as a valid/ready byte stream.
//   Filling one bank overlaps draining the other.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start_stb         start pulse (ignored while o_busy)
//   i_base_addr         first flash byte address of the transfer
//   i_num_blocks        blocks to stream (0 -> immediate o_done_stb)
//   o_busy, o_done_stb  transfer in progress / 1-cycle completion pulse
//   o_read_addr/_stb    block-read request to the controller
//   i_read_done_stb     controller finished the current block
//   i_wr_stb/addr/data  controller BRAM-write byte stream
//   o_tvalid/tdata/tlast, i_tready   output byte stream
module spi_flash_block_streamer #(
    parameter int BLOCK_SIZE = 512,
    parameter int NBLK_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start_stb,
    input  logic [23:0]       i_base_addr,
    input  logic [NBLK_W-1:0] i_num_blocks,
    output logic              o_busy,
    output logic              o_done_stb,
    output logic [23:0]       o_read_addr,
    output logic              o_read_stb,
    input  logic              i_read_done_stb,
    input  logic              i_wr_stb,
    input  logic [9:0]        i_wr_addr,
    input  logic [7:0]        i_wr_data,
    output logic              o_tvalid,
    output logic [7:0]        o_tdata,
    output logic              o_tlast,
    input  logic              i_tready
);

    localparam int PW = $clog2(BLOCK_SIZE + 1);   // drain pointer 0..BLOCK_SIZE
    localparam int MW = $clog2(2 * BLOCK_SIZE);   // buffer index

    typedef enum logic [1:0] {F_IDLE, F_ISSUE, F_FILL} fstate_t;
    typedef enum logic {D_IDLE, D_RUN} dstate_t;

    fstate_t           fstate;
    dstate_t           dstate;
    logic [23:0]       base;
    logic [NBLK_W-1:0] count;
    logic [NBLK_W-1:0] blk_issued;
    logic [NBLK_W-1:0] drain_blk;
    logic [1:0]        full;
    logic              fill_sel;
    logic              drain_sel;
    logic [PW-1:0]     ptr;          // next byte of the drain bank to fetch
    logic [7:0]        q;            // BRAM read register feeding o_tdata
    logic [7:0]        mem [0:2*BLOCK_SIZE-1];

    logic [23:0]       offset;
    logic              wr_ok;
    logic [MW-1:0]     widx;
    logic [MW-1:0]     ridx;
    logic              load;
    logic              accept;
    logic              bank_done;
    logic              last_byte;

    assign offset    = 24'(blk_issued) * 24'(BLOCK_SIZE);
    assign wr_ok     = (fstate == F_FILL) && i_wr_stb &&
                       ({1'b0, i_wr_addr} < 11'(BLOCK_SIZE));
    assign widx      = (fill_sel ? MW'(BLOCK_SIZE) : '0) + MW'(i_wr_addr);
    assign ridx      = (drain_sel ? MW'(BLOCK_SIZE) : '0) + MW'(ptr);
    assign accept    = o_tvalid && i_tready;
    assign bank_done = (ptr == PW'(BLOCK_SIZE));
    // Fetch straight into the output register whenever the output slot is
    // free or being emptied this cycle; this keeps one byte per cycle with
    // i_tready high and holds the current byte while stalled.
    assign load      = (dstate == D_RUN) && !bank_done && (!o_tvalid || i_tready);
    assign last_byte = (ptr == PW'(BLOCK_SIZE - 1)) &&
                       (drain_blk == count - NBLK_W'(1));

    // Plain synchronous-read buffer, no reset, so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[widx] <= i_wr_data;
        if (load)  q <= mem[ridx];
    end

    assign o_tdata = o_tvalid ? q : 8'h00;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fstate      <= F_IDLE;
            dstate      <= D_IDLE;
            base        <= '0;
            count       <= '0;
            blk_issued  <= '0;
            drain_blk   <= '0;
            full        <= '0;
            fill_sel    <= 1'b0;
            drain_sel   <= 1'b0;
            ptr         <= '0;
            o_busy      <= 1'b0;
            o_done_stb  <= 1'b0;
            o_read_addr <= '0;
            o_read_stb  <= 1'b0;
            o_tvalid    <= 1'b0;
            o_tlast     <= 1'b0;
        end else begin
            o_read_stb <= 1'b0;
            o_done_stb <= 1'b0;

            // !o_busy implies both FSMs are idle, so this cannot collide
            // with the state updates below.
            if (i_start_stb && !o_busy) begin
                if (i_num_blocks == '0) begin
                    o_done_stb <= 1'b1;
                end else begin
                    o_busy     <= 1'b1;
                    base       <= i_base_addr;
                    count      <= i_num_blocks;
                    blk_issued <= '0;
                    drain_blk  <= '0;
                    fstate     <= F_ISSUE;
                end
            end

            // Fill side
            case (fstate)
                F_ISSUE: begin
                    if (!full[fill_sel]) begin
                        o_read_stb  <= 1'b1;
                        o_read_addr <= base + offset;
                        fstate      <= F_FILL;
                    end
                end
                F_FILL: begin
                    if (i_read_done_stb) begin
                        full[fill_sel] <= 1'b1;
                        fill_sel       <= ~fill_sel;
                        blk_issued     <= blk_issued + 1'b1;
                        fstate <= (({1'b0, blk_issued} + 1'b1) < {1'b0, count}) ?
                                  F_ISSUE : F_IDLE;
                    end
                end
                default: ;
            endcase

            // Drain side; clears a different bank bit than fill ever sets
            case (dstate)
                D_IDLE: begin
                    if (o_busy && full[drain_sel]) dstate <= D_RUN;
                end
                D_RUN: begin
                    if (load) begin
                        o_tvalid <= 1'b1;
                        o_tlast  <= last_byte;
                        ptr      <= ptr + 1'b1;
                    end else if (accept) begin
                        o_tvalid <= 1'b0;
                        o_tlast  <= 1'b0;
                    end
                    // Output holds the bank's final byte; once taken the
                    // bank is free for refill.
                    if (accept && bank_done) begin
                        full[drain_sel] <= 1'b0;
                        drain_sel       <= ~drain_sel;
                        ptr             <= '0;
                        drain_blk       <= drain_blk + 1'b1;
                        if (!full[~drain_sel]) dstate <= D_IDLE;
                        if (o_tlast) begin
                            o_busy     <= 1'b0;
                            o_done_stb <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_block_streamer.sv
// Bench for spi_flash_block_streamer: a behavioural spi_flash_ctrl model
// answers read requests, expected read addresses and stream bytes are queued
// at stimulus time and compared as the DUT produces them.
module tb_spi_flash_block_streamer;

    localparam int BS = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] base_addr;
    logic [15:0] num_blocks;
    logic        busy, done_stb, read_stb, tvalid, tlast;
    logic [23:0] read_addr;
    logic [7:0]  tdata;
    logic        rd_done, wr_stb;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        tready;

    spi_flash_block_streamer #(.BLOCK_SIZE(BS), .NBLK_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start_stb(start),
        .i_base_addr(base_addr), .i_num_blocks(num_blocks),
        .o_busy(busy), .o_done_stb(done_stb),
        .o_read_addr(read_addr), .o_read_stb(read_stb),
        .i_read_done_stb(rd_done), .i_wr_stb(wr_stb),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_tvalid(tvalid), .o_tdata(tdata), .o_tlast(tlast),
        .i_tready(tready)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int n_reads = 0, n_bytes = 0, n_last = 0, n_done = 0;
    logic [23:0] exp_addr[$];
    logic [8:0]  exp_byte[$];
    int rd_cyc_q[$];
    int blk_end_q[$];
    bit rnd_rdy = 1'b0;
    bit rdy_fix = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [23:0] a, input int k);
        return 8'(k) + a[16:9];
    endfunction

    initial forever begin @(posedge clk); cyc++; end

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            tready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    // Controller model
    task automatic fill(input logic [23:0] a);
        repeat (2) @(posedge clk);
        for (int k = -1; k < BS; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                @(posedge clk); #1;
                wr_stb = 1'b0;
            end
            @(posedge clk); #1;
            if (rst) begin wr_stb = 1'b0; return; end
            wr_stb  = 1'b1;
            wr_addr = (k < 0) ? 10'd517 : 10'(k);   // out-of-range write first
            wr_data = (k < 0) ? 8'hA5 : fbyte(a, k);
        end
        @(posedge clk); #1;
        wr_stb = 1'b0;
        if (rst) return;
        rd_done = 1'b1;
        @(posedge clk); #1;
        rd_done = 1'b0;
    endtask

    initial begin : ctrl_model
        logic [23:0] a;
        wr_stb = 1'b0; wr_addr = '0; wr_data = '0; rd_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && read_stb) begin
                a = read_addr;
                n_reads++;
                rd_cyc_q.push_back(cyc);
                if (exp_addr.size() == 0) chk("read_extra", exp_addr.size(), 1);
                else chk("read_addr", a, exp_addr.pop_front());
                fill(a);
            end
        end
    end

    // Sink monitor
    initial begin : sink_mon
        logic [8:0] e;
        logic [8:0] held;
        bit stall;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin stall = 1'b0; continue; end
            if (stall) chk("hold_stable", {tvalid, tlast, tdata}, {1'b1, held});
            stall = tvalid && !tready;
            held  = {tlast, tdata};
            if (done_stb) n_done++;
            if (tvalid && tready) begin
                n_bytes++;
                if (tlast) n_last++;
                if (n_bytes % BS == 0) blk_end_q.push_back(cyc);
                if (exp_byte.size() == 0) chk("byte_extra", exp_byte.size(), 1);
                else begin
                    e = exp_byte.pop_front();
                    chk("byte", {tlast, tdata}, e);
                end
            end
        end
    end

    task automatic push_exp(input logic [23:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            logic [23:0] a;
            a = b + 24'(i * BS);
            exp_addr.push_back(a);
            for (int k = 0; k < BS; k++)
                exp_byte.push_back({(i == n - 1) && (k == BS - 1), fbyte(a, k)});
        end
    endtask

    task automatic pulse(input logic [23:0] b, input int n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_blocks = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int t;
        t = 0;
        while (n_done == d0 && t < 20000) begin @(negedge clk); t++; end
        chk({tag, "_done_seen"}, n_done != d0, 1);
    endtask

    task automatic run(input string tag, input logic [23:0] b, input int n,
                       input int stall, input bit poke);
        int r0, b0, l0, d0;
        r0 = n_reads; b0 = n_bytes; l0 = n_last; d0 = n_done;
        push_exp(b, n);
        if (stall > 0) rdy_fix = 1'b0;
        pulse(b, n);
        if (poke) begin
            repeat (5) @(posedge clk);
            chk({tag, "_busy"}, busy, 1);
            pulse(24'h800000, 7);                    // must be ignored
        end
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            chk({tag, "_stall_reads"}, n_reads - r0, 2);
            chk({tag, "_stall_bytes"}, n_bytes - b0, 0);
            rdy_fix = 1'b1;
        end
        wait_done(tag, d0);
        repeat (5) @(negedge clk);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_reads"}, n_reads - r0, n);
        chk({tag, "_bytes"}, n_bytes - b0, n * BS);
        chk({tag, "_tlast"}, n_last - l0, 1);
        chk({tag, "_done_cnt"}, n_done - d0, 1);
        chk({tag, "_q_bytes"}, exp_byte.size(), 0);
        chk({tag, "_q_addrs"}, exp_addr.size(), 0);
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d expected < 70000", cyc);
        $fatal(1);
    end

    initial begin
        int r0, e0, b0, d0, t, rc, ec;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_blocks = '0;
        repeat (3) @(posedge clk); #1;
        chk("reset_outs", {busy, done_stb, read_stb, tvalid, tlast, tdata, read_addr}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run("t1", 24'h000100, 1, 0, 1'b0);

        r0 = rd_cyc_q.size(); e0 = blk_end_q.size();
        run("t2", 24'h000100, 3, 0, 1'b0);
        rc = (rd_cyc_q.size() > r0 + 1) ? rd_cyc_q[r0 + 1] : 32'h7fffffff;
        ec = (blk_end_q.size() > e0) ? blk_end_q[e0] : 0;
        chk("t2_overlap", rc < ec, 1);

        run("t3", 24'h010000, 4, 3000, 1'b0);

        rnd_rdy = 1'b1;
        run("t4", 24'hFFFF00, 2, 0, 1'b0);
        rnd_rdy = 1'b0;

        // Zero blocks: immediate done, never busy, no read
        r0 = n_reads;
        pulse(24'h001000, 0);
        @(negedge clk);
        chk("t5_done", done_stb, 1);
        chk("t5_busy", busy, 0);
        @(negedge clk);
        chk("t5_done_1cyc", done_stb, 0);
        chk("t5_no_read", n_reads - r0, 0);
        run("t5b", 24'h002000, 1, 0, 1'b1);

        // Reset in the middle of block 2
        b0 = n_bytes; d0 = n_done;
        push_exp(24'h003000, 3);
        pulse(24'h003000, 3);
        t = 0;
        while (n_bytes - b0 < 600 && t < 20000) begin @(negedge clk); t++; end
        chk("t6_reached_blk2", n_bytes - b0 >= 600, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_outs", {busy, done_stb, read_stb, tvalid, tlast, tdata, read_addr}, 0);
        exp_byte.delete();
        exp_addr.delete();
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_no_done", n_done - d0, 0);
        run("t6b", 24'h004000, 2, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
